// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch button controller.
package stopwatch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam int DB_CYCLES_DEF = 1_000_000;
endpackage

// File: rtl/stopwatch_btn_ctrl_if.sv
// Button inputs and stopwatch control outputs; slave is the controller side.
interface stopwatch_btn_ctrl_if;
    logic btn_start_raw;
    logic btn_clr_raw;
    logic cnt_en;
    logic clr;
    logic paused;

    modport master (output btn_start_raw, btn_clr_raw, input cnt_en, clr, paused);
    modport slave  (input btn_start_raw, btn_clr_raw, output cnt_en, clr, paused);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge press detect.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic arst_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          db_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync   <= '0;
            cnt    <= '0;
            btn_db <= 1'b0;
            db_q   <= 1'b0;
        end else begin
            sync <= {sync[0], btn_raw};
            db_q <= btn_db;
            // Any sample matching the accepted level restarts the stability window.
            if (sync[1] == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                btn_db <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = btn_db & ~db_q;
endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Start/stop and clear button controller driving a stopwatch's cnt_en/clr.
module stopwatch_btn_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  arst_n,
    stopwatch_btn_ctrl_if.slave   bus
);
    // Bit 0 is start, bit 1 is clear.
    logic [1:0] press;
    logic [1:0] db_unused;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [1:0] (
        .clk     (clk),
        .arst_n  (arst_n),
        .btn_raw ({bus.btn_clr_raw, bus.btn_start_raw}),
        .btn_db  (db_unused),
        .press   (press)
    );

    sw_state_e state, state_nxt;
    logic      cnt_en_nxt, paused_nxt, clr_nxt;

    always_comb begin
        state_nxt = state;
        // Clear takes priority over a simultaneous start press.
        if (press[1]) begin
            state_nxt = IDLE;
        end else if (press[0]) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
        cnt_en_nxt = (state_nxt == RUN);
        paused_nxt = (state_nxt == PAUSE);
        clr_nxt    = press[1];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            bus.cnt_en <= 1'b0;
            bus.paused <= 1'b0;
            bus.clr    <= 1'b0;
        end else begin
            state      <= state_nxt;
            bus.cnt_en <= cnt_en_nxt;
            bus.paused <= paused_nxt;
            bus.clr    <= clr_nxt;
        end
    end
endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Directed bench for stopwatch_btn_ctrl with DB_CYCLES=4; outputs checked as {cnt_en,paused,clr}.
module tb_stopwatch_btn_ctrl;
    logic clk = 1'b0;
    logic arst_n;
    int   errs = 0;
    int   checks = 0;
    int   clr_hi = 0;
    int   base;

    always #5 clk = ~clk;

    stopwatch_btn_ctrl_if bus ();

    stopwatch_btn_ctrl #(.DB_CYCLES(4)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after an edge, so the next edge is edge 1 of a step.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.clr === 1'b1) clr_hi++;
        end
    endtask

    function automatic logic [2:0] outs();
        return {bus.cnt_en, bus.paused, bus.clr};
    endfunction

    initial begin
        arst_n = 1'b0;
        bus.btn_start_raw = 1'b0;
        bus.btn_clr_raw   = 1'b0;
        tick(3);
        chk("reset", 32'(outs()), 32'(3'b000));
        arst_n = 1'b1;
        tick(2);

        // Short glitch never reaches db.
        bus.btn_start_raw = 1'b1;
        tick(3);
        bus.btn_start_raw = 1'b0;
        tick(10);
        chk("glitch", 32'(outs()), 32'(3'b000));

        // Clean start press held 20 cycles.
        base = clr_hi;
        bus.btn_start_raw = 1'b1;
        tick(6);
        chk("start_e6", 32'(outs()), 32'(3'b000));
        tick(1);
        chk("start_e7", 32'(outs()), 32'(3'b100));
        tick(13);
        chk("start_hold", 32'(outs()), 32'(3'b100));
        chk("start_noclr", 32'(clr_hi - base), 32'd0);
        bus.btn_start_raw = 1'b0;
        tick(10);
        chk("start_rel", 32'(outs()), 32'(3'b100));

        // RUN -> PAUSE -> RUN.
        bus.btn_start_raw = 1'b1;
        tick(6);
        chk("pause_e6", 32'(outs()), 32'(3'b100));
        tick(1);
        chk("pause_e7", 32'(outs()), 32'(3'b010));
        bus.btn_start_raw = 1'b0;
        tick(10);
        bus.btn_start_raw = 1'b1;
        tick(7);
        chk("resume", 32'(outs()), 32'(3'b100));
        bus.btn_start_raw = 1'b0;
        tick(10);

        // Clear while running.
        base = clr_hi;
        bus.btn_clr_raw = 1'b1;
        tick(6);
        chk("clr_e6", 32'(outs()), 32'(3'b100));
        tick(1);
        chk("clr_e7", 32'(outs()), 32'(3'b001));
        tick(1);
        chk("clr_e8", 32'(outs()), 32'(3'b000));
        tick(10);
        chk("clr_once", 32'(clr_hi - base), 32'd1);
        bus.btn_clr_raw = 1'b0;
        tick(10);

        // Simultaneous start and clear from IDLE: clear wins.
        base = clr_hi;
        bus.btn_start_raw = 1'b1;
        bus.btn_clr_raw   = 1'b1;
        tick(7);
        chk("both_e7", 32'(outs()), 32'(3'b001));
        tick(12);
        chk("both_hold", 32'(outs()), 32'(3'b000));
        chk("both_once", 32'(clr_hi - base), 32'd1);
        bus.btn_start_raw = 1'b0;
        bus.btn_clr_raw   = 1'b0;
        tick(10);

        // Reset pulse mid-debounce while running, button held through it.
        bus.btn_start_raw = 1'b1;
        tick(7);
        chk("run_again", 32'(outs()), 32'(3'b100));
        bus.btn_start_raw = 1'b0;
        tick(10);
        bus.btn_start_raw = 1'b1;
        tick(4);
        arst_n = 1'b0;
        #1;
        chk("rst_async", 32'(outs()), 32'(3'b000));
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        tick(6);
        chk("rst_e6", 32'(outs()), 32'(3'b000));
        tick(1);
        chk("rst_e7", 32'(outs()), 32'(3'b100));
        bus.btn_start_raw = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
